// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcode/funct constants,
// FSM states, instruction classes and the datapath select encodings.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    DST_RT   = 2'd0,
    DST_RD   = 2'd1,
    DST_LINK = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_t;

  typedef enum logic [3:0] {
    IC_RALU = 4'd0,
    IC_JR   = 4'd1,
    IC_LW   = 4'd2,
    IC_SW   = 4'd3,
    IC_J    = 4'd4,
    IC_JAL  = 4'd5,
    IC_BEQ  = 4'd6,
    IC_BNE  = 4'd7,
    IC_ADDI = 4'd8,
    IC_XORI = 4'd9,
    IC_NONE = 4'd15
  } iclass_t;

endpackage

// File: rtl/ctrl_op_classify.sv
// Combinational opcode/funct decode into an instruction class, a legal flag
// and the ALU operation used by R-type arithmetic.
module ctrl_op_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_class,
  output logic       o_legal,
  output logic [2:0] o_alu_op
);

  iclass_t w_class;
  alu_op_t w_alu_op;

  always_comb begin
    w_class  = IC_NONE;
    w_alu_op = ALU_ADD;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD: begin
            w_class  = IC_RALU;
            w_alu_op = ALU_ADD;
          end
          FN_SUB: begin
            w_class  = IC_RALU;
            w_alu_op = ALU_SUB;
          end
          FN_SLT: begin
            w_class  = IC_RALU;
            w_alu_op = ALU_SLT;
          end
          FN_JR:   w_class = IC_JR;
          default: w_class = IC_NONE;
        endcase
      end
      OP_LW:   w_class = IC_LW;
      OP_SW:   w_class = IC_SW;
      OP_J:    w_class = IC_J;
      OP_JAL:  w_class = IC_JAL;
      OP_BEQ:  w_class = IC_BEQ;
      OP_BNE:  w_class = IC_BNE;
      OP_ADDI: w_class = IC_ADDI;
      OP_XORI: w_class = IC_XORI;
      default: w_class = IC_NONE;
    endcase
  end

  assign o_class  = w_class;
  assign o_legal  = (w_class != IC_NONE);
  assign o_alu_op = w_alu_op;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the single-issue datapath.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic             imm_zext,
  output logic [2:0]       alu_op,
  output logic             retired,
  output logic             illegal,
`ifdef INSTR_COUNT_EN
  output logic [CNT_W-1:0] instr_count,
`endif
  output logic [2:0]       o_dbg_state
);

  // Memory handshake: mem_req is held with a stable address select until a
  // cycle in which mem_ready is high; that cycle completes the request.
  // mem_ready in any cycle without mem_req is ignored.

  state_t     r_state;
  logic       r_illegal;

  logic [3:0] w_class_bits;
  iclass_t    w_class;
  logic       w_legal;
  logic [2:0] w_rfn_alu_op;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_addr_sel;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_reg_we;
  logic       w_alu_src_imm;
  logic       w_imm_zext;
  logic       w_retired;
  pc_src_t    w_pc_src;
  reg_dst_t   w_reg_dst;
  wb_sel_t    w_wb_sel;
  alu_op_t    w_alu_op;
  logic       w_live;

  ctrl_op_classify u_classify (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_class  (w_class_bits),
    .o_legal  (w_legal),
    .o_alu_op (w_rfn_alu_op)
  );

  assign w_class = iclass_t'(w_class_bits);

  // IR is only loaded at the end of FETCH, so opcode stays valid for the
  // whole instruction and later states can keep decoding it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          case (w_class)
            IC_LW, IC_SW:               r_state <= S_MEM;
            IC_RALU, IC_ADDI, IC_XORI:  r_state <= S_WB;
            default:                    r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready) r_state <= (w_class == IC_SW) ? S_FETCH : S_WB;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_addr_sel    = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_reg_we      = 1'b0;
    w_alu_src_imm = 1'b0;
    w_imm_zext    = 1'b0;
    w_retired     = 1'b0;
    w_pc_src      = PC_PLUS4;
    w_reg_dst     = DST_RT;
    w_wb_sel      = WB_ALU;
    w_alu_op      = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we  = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_src = PC_PLUS4;
        end
      end
      S_EXEC: begin
        case (w_class)
          IC_RALU: w_alu_op = alu_op_t'(w_rfn_alu_op);
          IC_ADDI, IC_LW, IC_SW: w_alu_src_imm = 1'b1;
          IC_XORI: begin
            w_alu_op      = ALU_XOR;
            w_alu_src_imm = 1'b1;
            w_imm_zext    = 1'b1;
          end
          IC_BEQ, IC_BNE: begin
            w_alu_op  = ALU_SUB;
            w_pc_src  = PC_BRANCH;
            w_pc_we   = (w_class == IC_BEQ) ? alu_zero : ~alu_zero;
            w_retired = 1'b1;
          end
          IC_J: begin
            w_pc_we   = 1'b1;
            w_pc_src  = PC_JUMP;
            w_retired = 1'b1;
          end
          IC_JAL: begin
            // Link register takes PC, which already holds PC+4 after FETCH.
            w_pc_we   = 1'b1;
            w_pc_src  = PC_JUMP;
            w_reg_we  = 1'b1;
            w_reg_dst = DST_LINK;
            w_wb_sel  = WB_PC;
            w_retired = 1'b1;
          end
          IC_JR: begin
            w_pc_we   = 1'b1;
            w_pc_src  = PC_RS;
            w_retired = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = (w_class == IC_SW);
        w_retired  = mem_ready && (w_class == IC_SW);
      end
      S_WB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = (w_class == IC_RALU) ? DST_RD : DST_RT;
        w_wb_sel  = (w_class == IC_LW) ? WB_MEM : WB_ALU;
        w_retired = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset idles the whole control bundle in the same cycle, abandoning any
  // outstanding memory request.
  assign w_live       = ~reset;
  assign mem_req      = w_mem_req & w_live;
  assign mem_we       = w_mem_we & w_live;
  assign mem_addr_sel = w_addr_sel & w_live;
  assign ir_we        = w_ir_we & w_live;
  assign pc_we        = w_pc_we & w_live;
  assign pc_src       = w_live ? w_pc_src : 2'd0;
  assign reg_we       = w_reg_we & w_live;
  assign reg_dst      = w_live ? w_reg_dst : 2'd0;
  assign wb_sel       = w_live ? w_wb_sel : 2'd0;
  assign alu_src_imm  = w_alu_src_imm & w_live;
  assign imm_zext     = w_imm_zext & w_live;
  assign alu_op       = w_live ? w_alu_op : 3'd0;
  assign retired      = w_retired & w_live;
  assign illegal      = r_illegal;
  assign o_dbg_state  = r_state;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (retired) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign instr_count = r_instr_count;

  logic w_unused_cfg;
  assign w_unused_cfg = (LINK_REG == 31);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (LINK_REG == 31) ^ (CNT_W == 32);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected control vectors
// are queued with their stimulus and compared as the FSM steps through them.
module tb_multicycle_ctrl_fsm;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq;
    logic       mwe;
    logic       asel;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       rwe;
    logic [1:0] rdst;
    logic [1:0] wsel;
    logic       imm;
    logic       zext;
    logic [2:0] aop;
    logic       ret;
    logic       ill;
  } ovec_t;

  localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_ADDI = 3, K_XORI = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9;
  localparam int K_JAL = 10, K_JR = 11, K_BAD = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_src, reg_dst, wb_sel;
  logic        reg_we, alu_src_imm, imm_zext, retired, illegal;
  logic [2:0]  alu_op;
  logic [2:0]  dbg_state;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .alu_zero     (alu_zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .wb_sel       (wb_sel),
    .alu_src_imm  (alu_src_imm),
    .imm_zext     (imm_zext),
    .alu_op       (alu_op),
    .retired      (retired),
    .illegal      (illegal),
`ifdef INSTR_COUNT_EN
    .instr_count  (instr_count),
`endif
    .o_dbg_state  (dbg_state)
  );

  logic [21:0] exp_q[$];
  logic [1:0]  stim_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_cycle(input string tag, input ovec_t e, input logic rst, input logic rdy);
    exp_q.push_back(e);
    stim_q.push_back({rst, rdy});
    tag_q.push_back(tag);
    if (e.ret) m_count++;
    if (rst) m_count = 0;
  endtask

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: return K_ADD;
          6'b100010: return K_SUB;
          6'b101010: return K_SLT;
          6'b001000: return K_JR;
          default:   return K_BAD;
        endcase
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b001000: return K_ADDI;
      6'b001110: return K_XORI;
      default:   return K_BAD;
    endcase
  endfunction

  // Builds the full expected cycle sequence for one instruction.
  task automatic queue_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int fwait, input int mwait, input bit abort_mem);
    ovec_t e;
    int    k;
    k = kind_of(op, fn);
    for (int i = 0; i < fwait; i++) begin
      e = '0; e.st = S_FETCH; e.mreq = 1'b1;
      push_cycle({nm, "_fetch_wait"}, e, 1'b0, 1'b0);
    end
    e = '0; e.st = S_FETCH; e.mreq = 1'b1; e.irwe = 1'b1; e.pcwe = 1'b1;
    push_cycle({nm, "_fetch"}, e, 1'b0, 1'b1);
    e = '0; e.st = S_DECODE;
    push_cycle({nm, "_decode"}, e, 1'b0, 1'($urandom_range(0, 1)));
    if (k == K_BAD) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.st = S_TRAP; e.ill = 1'b1;
        push_cycle({nm, "_trap"}, e, 1'b0, 1'($urandom_range(0, 1)));
      end
      e = '0; e.st = S_TRAP; e.ill = 1'b1;
      push_cycle({nm, "_trap_reset"}, e, 1'b1, 1'b0);
      return;
    end
    e = '0; e.st = S_EXEC;
    case (k)
      K_ADD:  e.aop = 3'd0;
      K_SUB:  e.aop = 3'd1;
      K_SLT:  e.aop = 3'd3;
      K_ADDI, K_LW, K_SW: e.imm = 1'b1;
      K_XORI: begin e.aop = 3'd2; e.imm = 1'b1; e.zext = 1'b1; end
      K_BEQ:  begin e.aop = 3'd1; e.pcsrc = 2'd1; e.pcwe = zero;  e.ret = 1'b1; end
      K_BNE:  begin e.aop = 3'd1; e.pcsrc = 2'd1; e.pcwe = ~zero; e.ret = 1'b1; end
      K_J:    begin e.pcwe = 1'b1; e.pcsrc = 2'd2; e.ret = 1'b1; end
      K_JAL:  begin e.pcwe = 1'b1; e.pcsrc = 2'd2; e.rwe = 1'b1; e.rdst = 2'd2; e.wsel = 2'd2; e.ret = 1'b1; end
      K_JR:   begin e.pcwe = 1'b1; e.pcsrc = 2'd3; e.ret = 1'b1; end
      default: ;
    endcase
    push_cycle({nm, "_exec"}, e, 1'b0, 1'($urandom_range(0, 1)));
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < mwait; i++) begin
        e = '0; e.st = S_MEM; e.mreq = 1'b1; e.asel = 1'b1; e.mwe = (k == K_SW);
        push_cycle({nm, "_mem_wait"}, e, 1'b0, 1'b0);
        if (abort_mem) begin
          e = '0; e.st = S_MEM;
          push_cycle({nm, "_mem_reset"}, e, 1'b1, 1'b1);
          return;
        end
      end
      e = '0; e.st = S_MEM; e.mreq = 1'b1; e.asel = 1'b1; e.mwe = (k == K_SW); e.ret = (k == K_SW);
      push_cycle({nm, "_mem"}, e, 1'b0, 1'b1);
    end
    if (k == K_ADD || k == K_SUB || k == K_SLT || k == K_ADDI || k == K_XORI || k == K_LW) begin
      e = '0; e.st = S_WB; e.rwe = 1'b1; e.ret = 1'b1;
      e.rdst = (k == K_ADD || k == K_SUB || k == K_SLT) ? 2'd1 : 2'd0;
      e.wsel = (k == K_LW) ? 2'd1 : 2'd0;
      push_cycle({nm, "_wb"}, e, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_queue();
    logic [1:0] s;
    ovec_t      g;
    logic [21:0] e;
    string      t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s[1];
      mem_ready = s[0];
      #1;
      g = '0;
      g.st = dbg_state; g.mreq = mem_req; g.mwe = mem_we; g.asel = mem_addr_sel;
      g.irwe = ir_we; g.pcwe = pc_we; g.pcsrc = pc_src; g.rwe = reg_we;
      g.rdst = reg_dst; g.wsel = wb_sel; g.imm = alu_src_imm; g.zext = imm_zext;
      g.aop = alu_op; g.ret = retired; g.ill = illegal;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {10'd0, g}, {10'd0, e});
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic zero, input int fwait, input int mwait, input bit abort_mem);
    opcode = op;
    funct = fn;
    alu_zero = zero;
    queue_instr(nm, op, fn, zero, fwait, mwait, abort_mem);
    run_queue();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ovec_t e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '0; e.st = S_FETCH;
    push_cycle("reset_state", e, 1'b1, 1'b1);
    run_queue();

    do_instr("add",    6'b000000, 6'b100000, 1'b0, 0, 0, 1'b0);
    do_instr("sub",    6'b000000, 6'b100010, 1'b1, 2, 0, 1'b0);
    do_instr("slt",    6'b000000, 6'b101010, 1'b0, 1, 0, 1'b0);
    do_instr("addi",   6'b001000, 6'b010101, 1'b0, 0, 0, 1'b0);
    do_instr("xori",   6'b001110, 6'b111111, 1'b0, 0, 0, 1'b0);
    do_instr("lw",     6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);
    do_instr("sw",     6'b101011, 6'b000000, 1'b0, 0, 1, 1'b0);
    do_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);
    do_instr("bne_z1", 6'b000101, 6'b000000, 1'b1, 0, 0, 1'b0);
    do_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 0, 0, 1'b0);
    do_instr("bne_z0", 6'b000101, 6'b000000, 1'b0, 1, 0, 1'b0);
    do_instr("j",      6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);
    do_instr("jal",    6'b000011, 6'b000000, 1'b0, 0, 0, 1'b0);
    do_instr("jr",     6'b000000, 6'b001000, 1'b0, 0, 0, 1'b0);
    do_instr("bad_op", 6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
    do_instr("bad_fn", 6'b000000, 6'b000000, 1'b0, 0, 0, 1'b0);
    do_instr("lw_abort", 6'b100011, 6'b000000, 1'b0, 0, 3, 1'b1);

    do_instr("mix_add", 6'b000000, 6'b100000, 1'b0, $urandom_range(0, 2), 0, 1'b0);
    do_instr("mix_sw",  6'b101011, 6'b000000, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    do_instr("mix_beq", 6'b000100, 6'b000000, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0, 1'b0);
    do_instr("mix_j",   6'b000010, 6'b000000, 1'b0, $urandom_range(0, 2), 0, 1'b0);
    do_instr("mix_lw",  6'b100011, 6'b000000, 1'b0, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);

`ifdef INSTR_COUNT_EN
    check("instr_count", instr_count, 32'(m_count));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
